return_address_stack: RTL and testbench

//  Fetch-side return address stack (RAS) for the RV32I pipeline. Consumes the
//  PC+4 link address produced for JAL/JALR calls (rd=x1/x5) and pushes it.

---
 rtl/rv32_bp_pkg.sv | 13 +
 rtl/ras_ptr_ctrl.sv | 88 ++++++++
 rtl/return_address_stack.sv | 84 ++++++++
 tb/tb_return_address_stack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bp_pkg.sv
// Shared branch-prediction constants and types for the RV32I fetch side.
// Used by the return address stack, the fetch stage and the YAGS wrapper.
package rv32_bp_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAS_DEPTH = 8;

  // Slot index into the RAS storage array; wraps mod RAS_DEPTH.
  typedef logic [$clog2(RAS_DEPTH)-1:0] ras_ptr_t;
  // Live-entry count, 0..RAS_DEPTH inclusive, hence one extra bit.
  typedef logic [$clog2(RAS_DEPTH):0]   ras_cnt_t;

endpackage

// File: rtl/ras_ptr_ctrl.sv
// Pointer/count controller for the return address stack.
// Owns wr_ptr (next free slot) and the saturating live-entry count, and decodes
// the storage write enable/index for push, pop and push+pop (swap) cycles.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push_i      call detected
//   pop_i       return detected
//   flush_i     redirect: drop all live entries (highest priority)
//   wr_en_o     write push data into storage this cycle
//   wr_idx_o    storage slot written when wr_en_o is set
//   top_idx_o   slot currently holding the top of stack (wr_ptr - 1)
//   count_o     live entries, 0..DEPTH
//   full_o      count_o == DEPTH
module ras_ptr_ctrl #(
  parameter int unsigned DEPTH = rv32_bp_pkg::RAS_DEPTH,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            wr_en_o,
  output logic [PtrW-1:0] wr_idx_o,
  output logic [PtrW-1:0] top_idx_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;
  logic do_swap;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // Push+pop on an empty stack has nothing to replace, so it degrades to a push.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_swap = 1'b0;
    if (!flush_i) begin
      do_swap = push_i && pop_i && !empty;
      do_push = push_i && !do_swap;
      do_pop  = pop_i && !push_i && !empty;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Entries and wr_ptr are kept; only the live count is dropped.
      count_d = '0;
    end else if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (!full) begin
        count_d = count_q + CntW'(1);
      end
    end else if (do_pop) begin
      wr_ptr_d = wr_ptr_q - PtrW'(1);
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign top_idx_o = wr_ptr_q - PtrW'(1);
  assign wr_en_o   = do_push || do_swap;
  assign wr_idx_o  = do_swap ? top_idx_o : wr_ptr_q;
  assign count_o   = count_q;
  assign full_o    = full;

endmodule

// File: rtl/return_address_stack.sv
// Fetch-side return address stack for the RV32I pipeline.
// Calls push their link address (PC+4); returns read the top entry as the
// predicted target. Circular LIFO: overflow overwrites the oldest entry, and a
// redirect flush empties the stack without touching storage.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        call detected: push push_addr_i
//   push_addr_i   link address (call PC + 4), stored unmodified
//   pop_i         return detected: pop top entry
//   flush_i       pipeline redirect: empty the stack (beats push/pop)
//   top_addr_o    predicted return target, 0 when empty
//   top_valid_o   stack non-empty
//   count_o       live entries, 0..DEPTH
//   full_o        count_o == DEPTH
// All outputs come from registered state only.
module return_address_stack #(
  parameter int unsigned XLEN  = rv32_bp_pkg::XLEN,
  parameter int unsigned DEPTH = rv32_bp_pkg::RAS_DEPTH,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] top_addr_o,
  output logic            top_valid_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  logic [XLEN-1:0] entries_q [DEPTH];
  logic [XLEN-1:0] entries_d [DEPTH];

  logic            wr_en;
  logic [PtrW-1:0] wr_idx;
  logic [PtrW-1:0] top_idx;
  logic [CntW-1:0] count;
  logic            full;

  ras_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_i),
    .pop_i     (pop_i),
    .flush_i   (flush_i),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .top_idx_o (top_idx),
    .count_o   (count),
    .full_o    (full)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (wr_en) begin
      entries_d[wr_idx] = push_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  assign top_valid_o = (count != '0);
  assign top_addr_o  = top_valid_o ? entries_q[top_idx] : '0;
  assign count_o     = count;
  assign full_o      = full;

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            push_i;
  logic [XLEN-1:0] push_addr_i;
  logic            pop_i;
  logic            flush_i;
  logic [XLEN-1:0] top_addr_o;
  logic            top_valid_o;
  logic [CntW-1:0] count_o;
  logic            full_o;

  return_address_stack #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_i),
    .push_addr_i (push_addr_i),
    .pop_i       (pop_i),
    .flush_i     (flush_i),
    .top_addr_o  (top_addr_o),
    .top_valid_o (top_valid_o),
    .count_o     (count_o),
    .full_o      (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            push;
    logic            pop;
    logic            flush;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] top;
    logic            valid;
    logic [CntW-1:0] cnt;
    logic            full;
  } vec_t;

  typedef struct {
    string           name;
    logic [XLEN-1:0] top;
    logic            valid;
    logic [CntW-1:0] cnt;
    logic            full;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(string name, logic push, logic pop, logic flush,
                              logic [XLEN-1:0] addr, logic [XLEN-1:0] top,
                              logic valid, int cnt, logic full);
    vec_t v;
    v.name  = name;
    v.push  = push;
    v.pop   = pop;
    v.flush = flush;
    v.addr  = addr;
    v.top   = top;
    v.valid = valid;
    v.cnt   = CntW'(cnt);
    v.full  = full;
    return v;
  endfunction

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(exp_t e);
    check({e.name, ".top"},   top_addr_o, e.top);
    check({e.name, ".valid"}, XLEN'(top_valid_o), XLEN'(e.valid));
    check({e.name, ".count"}, XLEN'(count_o), XLEN'(e.cnt));
    check({e.name, ".full"},  XLEN'(full_o), XLEN'(e.full));
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), queue the
  // expected result, then compare it just after the edge that applies it.
  task automatic apply(vec_t v);
    exp_t e;
    push_i      = v.push;
    pop_i       = v.pop;
    flush_i     = v.flush;
    push_addr_i = v.addr;
    e.name  = v.name;
    e.top   = v.top;
    e.valid = v.valid;
    e.cnt   = v.cnt;
    e.full  = v.full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      check_outputs(sb.pop_front());
    end
    push_i  = 1'b0;
    pop_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic idle();
    push_i  = 1'b0;
    pop_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    exp_t rst_exp;
    rst_exp.name  = "reset";
    rst_exp.top   = '0;
    rst_exp.valid = 1'b0;
    rst_exp.cnt   = '0;
    rst_exp.full  = 1'b0;

    idle();
    push_addr_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(rst_exp);
    rst = 1'b0;

    // LIFO ordering
    vecs.push_back(mk("lifo_push0", 1, 0, 0, 32'h104, 32'h104, 1, 1, 0));
    vecs.push_back(mk("lifo_push1", 1, 0, 0, 32'h208, 32'h208, 1, 2, 0));
    vecs.push_back(mk("lifo_push2", 1, 0, 0, 32'h30C, 32'h30C, 1, 3, 0));
    vecs.push_back(mk("lifo_pop0",  0, 1, 0, 32'h0,   32'h208, 1, 2, 0));
    vecs.push_back(mk("lifo_pop1",  0, 1, 0, 32'h0,   32'h104, 1, 1, 0));
    vecs.push_back(mk("lifo_pop2",  0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    // Underflow leaves pointer alone; next push lands on top
    vecs.push_back(mk("uflow_pop0", 0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    vecs.push_back(mk("uflow_pop1", 0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    vecs.push_back(mk("uflow_push", 1, 0, 0, 32'h40,  32'h40,  1, 1, 0));
    vecs.push_back(mk("uflow_pop2", 0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    // Push+pop swap, and push+pop on empty
    vecs.push_back(mk("swap_push0", 1, 0, 0, 32'h10,  32'h10,  1, 1, 0));
    vecs.push_back(mk("swap_push1", 1, 0, 0, 32'h20,  32'h20,  1, 2, 0));
    vecs.push_back(mk("swap",       1, 1, 0, 32'h99,  32'h99,  1, 2, 0));
    vecs.push_back(mk("swap_pop0",  0, 1, 0, 32'h0,   32'h10,  1, 1, 0));
    vecs.push_back(mk("swap_pop1",  0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    vecs.push_back(mk("swap_empty", 1, 1, 0, 32'h77,  32'h77,  1, 1, 0));
    vecs.push_back(mk("swap_pop2",  0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    // Flush beats push
    vecs.push_back(mk("fl_push0",   1, 0, 0, 32'hA,   32'hA,   1, 1, 0));
    vecs.push_back(mk("fl_push1",   1, 0, 0, 32'hB,   32'hB,   1, 2, 0));
    vecs.push_back(mk("fl_flush",   1, 0, 1, 32'hC,   32'h0,   0, 0, 0));
    vecs.push_back(mk("fl_push2",   1, 0, 0, 32'h50,  32'h50,  1, 1, 0));
    vecs.push_back(mk("fl_pop",     0, 1, 0, 32'h0,   32'h0,   0, 0, 0));
    // Overflow: ten pushes into eight slots, first two lost
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk($sformatf("ovf_push%0d", i), 1, 0, 0, 32'h1000 + 4 * i,
                        32'h1000 + 4 * i, 1, (i < 7) ? i + 1 : 8, i >= 7));
    end
    for (int j = 0; j < 8; j++) begin
      vecs.push_back(mk($sformatf("ovf_pop%0d", j), 0, 1, 0, 32'h0,
                        (j < 7) ? 32'h1000 + 4 * (8 - j) : 32'h0, j < 7, 7 - j, 0));
    end

    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      apply(vecs[k]);
    end

    // Asynchronous reset mid-stream after three pushes
    apply(mk("ar_push0", 1, 0, 0, 32'h300, 32'h300, 1, 1, 0));
    apply(mk("ar_push1", 1, 0, 0, 32'h304, 32'h304, 1, 2, 0));
    apply(mk("ar_push2", 1, 0, 0, 32'h308, 32'h308, 1, 3, 0));
    #2;
    rst = 1'b1;
    #1;
    rst_exp.name = "async_rst";
    check_outputs(rst_exp);
    // Held in reset across an edge even with a push pending
    push_i      = 1'b1;
    push_addr_i = 32'h400;
    @(posedge clk);
    #1;
    rst_exp.name = "rst_hold";
    check_outputs(rst_exp);
    idle();
    rst = 1'b0;
    apply(mk("post_rst_push", 1, 0, 0, 32'h44, 32'h44, 1, 1, 0));

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
